seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 134 +++++++++++++
 tb/tb_seg_scan_driver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner with double-buffered BCD data,
// per-slot anode blanking and optional leading-zero suppression.
module seg_scan_driver #(
    parameter int unsigned CLK_DIV   = 100000,
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bcd_in,
    input  logic [7:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an,
    output logic        pending,
    output logic        frame_done
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [31:0]      r_disp_bcd, r_shd_bcd;
    logic [7:0]       r_disp_dp, r_shd_dp;
    logic             r_pending, r_frame_done;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic [7:0]       r_an;

    logic             w_tick, w_boundary;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_idx_nxt;
    logic [31:0]      w_disp_bcd_nxt, w_shd_bcd_nxt;
    logic [7:0]       w_disp_dp_nxt, w_shd_dp_nxt;
    logic             w_pending_nxt;
    logic [3:0]       w_digit;
    logic             w_lz_blank;
    logic [6:0]       w_seg_dec, w_seg_nxt;
    logic             w_dp_nxt;
    logic [7:0]       w_an_nxt;

    always_comb begin
        w_tick     = (r_cnt == CNT_MAX);
        w_boundary = w_tick && (r_idx == 3'd7);
        w_cnt_nxt  = w_tick ? '0 : r_cnt + CNT_W'(1);
        w_idx_nxt  = w_tick ? r_idx + 3'd1 : r_idx;

        w_shd_bcd_nxt  = load ? bcd_in : r_shd_bcd;
        w_shd_dp_nxt   = load ? dp_in  : r_shd_dp;
        w_pending_nxt  = r_pending;
        w_disp_bcd_nxt = r_disp_bcd;
        w_disp_dp_nxt  = r_disp_dp;
        if (w_boundary) begin
            // A load on the boundary edge bypasses the shadow and lands in this frame.
            if (load) begin
                w_disp_bcd_nxt = bcd_in;
                w_disp_dp_nxt  = dp_in;
            end else if (r_pending) begin
                w_disp_bcd_nxt = r_shd_bcd;
                w_disp_dp_nxt  = r_shd_dp;
            end
            w_pending_nxt = 1'b0;
        end else if (load) begin
            w_pending_nxt = 1'b1;
        end

        w_digit    = w_disp_bcd_nxt[{w_idx_nxt, 2'b00} +: 4];
        w_lz_blank = blank_lz && (w_idx_nxt != 3'd0) &&
                     ((w_disp_bcd_nxt >> {w_idx_nxt, 2'b00}) == 32'd0);

        case (w_digit)
            4'd0:    w_seg_dec = 7'b0000001;
            4'd1:    w_seg_dec = 7'b1001111;
            4'd2:    w_seg_dec = 7'b0010010;
            4'd3:    w_seg_dec = 7'b0000110;
            4'd4:    w_seg_dec = 7'b1001100;
            4'd5:    w_seg_dec = 7'b0100100;
            4'd6:    w_seg_dec = 7'b0100000;
            4'd7:    w_seg_dec = 7'b0001111;
            4'd8:    w_seg_dec = 7'b0000000;
            4'd9:    w_seg_dec = 7'b0000100;
            default: w_seg_dec = 7'b1111110;
        endcase

        w_seg_nxt = 7'b1111111;
        w_dp_nxt  = 1'b1;
        w_an_nxt  = 8'hFF;
        if (w_cnt_nxt >= BLANK_END) begin
            w_dp_nxt = ~w_disp_dp_nxt[w_idx_nxt];
            if (!w_lz_blank) begin
                w_an_nxt  = ~(8'd1 << w_idx_nxt);
                w_seg_nxt = w_seg_dec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= 3'd0;
            r_disp_bcd   <= 32'd0;
            r_disp_dp    <= 8'd0;
            r_shd_bcd    <= 32'd0;
            r_shd_dp     <= 8'd0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_seg        <= 7'b1111111;
            r_dp         <= 1'b1;
            r_an         <= 8'hFF;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_disp_bcd   <= w_disp_bcd_nxt;
            r_disp_dp    <= w_disp_dp_nxt;
            r_shd_bcd    <= w_shd_bcd_nxt;
            r_shd_dp     <= w_shd_dp_nxt;
            r_pending    <= w_pending_nxt;
            r_frame_done <= w_boundary;
            r_seg        <= w_seg_nxt;
            r_dp         <= w_dp_nxt;
            r_an         <= w_an_nxt;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign pending    = r_pending;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised bench for seg_scan_driver against a cycle-count-based display model.
module tb_seg_scan_driver;

    localparam int unsigned CLK_DIV = 8;
    localparam int unsigned BLANK   = 2;
    localparam int          FRAME   = 8 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] bcd_in = 32'd0;
    logic [7:0]  dp_in = 8'd0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic        pending;
    logic        frame_done;

    seg_scan_driver #(
        .CLK_DIV  (CLK_DIV),
        .BLANK_CYC(BLANK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd_in    (bcd_in),
        .dp_in     (dp_in),
        .load      (load),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .pending   (pending),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model state: n = rising edges since reset release; display contents as shown.
    int          n;
    logic [31:0] m_bcd, m_sbcd;
    logic [7:0]  m_dp, m_sdp;
    bit          m_pend, m_fd;
    logic [6:0]  seg_tab [16];

    function automatic logic [17:0] model_out();
        int         c, k;
        logic [6:0] s;
        logic       d;
        logic [7:0] a;
        c = n % CLK_DIV;
        k = (n / CLK_DIV) % 8;
        s = 7'h7F;
        d = 1'b1;
        a = 8'hFF;
        if (c >= BLANK) begin
            d = ~m_dp[k];
            if (!(blank_lz && k != 0 && (m_bcd >> (4 * k)) == 32'd0)) begin
                a = ~(8'd1 << k);
                s = seg_tab[m_bcd[4*k +: 4]];
            end
        end
        return {s, d, a, m_pend, m_fd};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (n=%0d)", name, act, exp, n);
        end
    endtask

    task automatic model_reset();
        n = 0;
        m_bcd = 32'd0; m_sbcd = 32'd0;
        m_dp = 8'd0;   m_sdp = 8'd0;
        m_pend = 1'b0; m_fd = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model across the next edge, compare.
    task automatic cyc(input bit ld, input logic [31:0] b, input logic [7:0] p);
        load = ld;
        if (ld) begin
            bcd_in = b;
            dp_in  = p;
        end
        n++;
        if (n % FRAME == 0) begin
            if (ld) begin
                m_bcd = b; m_dp = p;
            end else if (m_pend) begin
                m_bcd = m_sbcd; m_dp = m_sdp;
            end
            m_pend = 1'b0;
            m_fd   = 1'b1;
        end else begin
            m_fd = 1'b0;
            if (ld) begin
                m_sbcd = b; m_sdp = p; m_pend = 1'b1;
            end
        end
        @(negedge clk);
        load = 1'b0;
        check("outputs {seg,dp,an,pending,frame_done}",
              32'({seg, dp, an, pending, frame_done}), 32'(model_out()));
    endtask

    task automatic run_to(input int target);
        while (n < target) cyc(1'b0, 32'd0, 8'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("reset outputs", 32'({seg, dp, an, pending, frame_done}),
              32'({7'h7F, 1'b1, 8'hFF, 1'b0, 1'b0}));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        int          nz;
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                    7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b1111110, 7'b1111110,
                    7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110};
        model_reset();
        @(negedge clk);
        do_reset();

        // Power-up scan of zeros
        cyc(1'b0, 32'd0, 8'd0);
        check("slot0 blank an", 32'(an), 32'hFF);
        cyc(1'b0, 32'd0, 8'd0);
        check("slot0 lit an", 32'(an), 32'hFE);
        check("slot0 lit seg", 32'(seg), 32'(7'b0000001));
        run_to(FRAME);
        check("frame_done pulse", 32'(frame_done), 32'd1);
        cyc(1'b0, 32'd0, 8'd0);
        check("frame_done one cycle", 32'(frame_done), 32'd0);

        // Mid-frame load waits for the boundary
        run_to(FRAME + 20);
        cyc(1'b1, 32'h12345678, 8'h00);
        check("pending after load", 32'(pending), 32'd1);
        check("display unchanged mid-frame", 32'(seg), 32'(7'b0000001));
        run_to(2 * FRAME + 2);
        check("digit0 = 8", 32'(seg), 32'(7'b0000000));
        check("pending cleared", 32'(pending), 32'd0);
        run_to(2 * FRAME + 58);
        check("digit7 = 1 seg", 32'(seg), 32'(7'b1001111));
        check("digit7 an", 32'(an), 32'h7F);

        // Last load wins
        run_to(3 * FRAME + 5);
        cyc(1'b1, 32'h11111111, 8'h00);
        cyc(1'b0, 32'd0, 8'd0);
        cyc(1'b1, 32'h22222222, 8'h00);
        run_to(4 * FRAME + 27);
        check("last load wins digit3", 32'(seg), 32'(7'b0010010));
        check("digit3 an", 32'(an), 32'hF7);

        // Load coincident with the 7->0 tick
        run_to(5 * FRAME - 1);
        cyc(1'b1, 32'h87654321, 8'h01);
        check("boundary load pending", 32'(pending), 32'd0);
        check("boundary load frame_done", 32'(frame_done), 32'd1);
        run_to(5 * FRAME + 2);
        check("boundary load digit0", 32'(seg), 32'(7'b1001111));
        check("boundary load dp0", 32'(dp), 32'd0);

        // Leading-zero suppression
        blank_lz = 1'b1;
        run_to(5 * FRAME + 10);
        cyc(1'b1, 32'h00000305, 8'h00);
        run_to(6 * FRAME + 2);
        check("lz digit0 = 5", 32'(seg), 32'(7'b0100100));
        run_to(6 * FRAME + 10);
        check("lz digit1 = 0", 32'(seg), 32'(7'b0000001));
        check("lz digit1 an", 32'(an), 32'hFD);
        run_to(6 * FRAME + 18);
        check("lz digit2 = 3", 32'(seg), 32'(7'b0000110));
        run_to(6 * FRAME + 26);
        check("lz digit3 blanked an", 32'(an), 32'hFF);
        check("lz digit3 blanked seg", 32'(seg), 32'(7'b1111111));

        // Dash for non-BCD digit
        blank_lz = 1'b0;
        run_to(6 * FRAME + 40);
        cyc(1'b1, 32'h0000000C, 8'h00);
        run_to(7 * FRAME + 2);
        check("digit 0xC dash", 32'(seg), 32'(7'b1111110));

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 15) == 0) begin
                r  = $urandom;
                nz = $urandom_range(0, 8);
                r  = (nz == 8) ? 32'd0 : (r & (32'hFFFFFFFF >> (4 * nz)));
                cyc(1'b1, r, 8'($urandom));
            end else begin
                cyc(1'b0, 32'd0, 8'd0);
            end
        end

        // Asynchronous reset mid-slot discards a pending load
        blank_lz = 1'b0;
        cyc(1'b1, 32'h99999999, 8'hFF);
        while ((n % CLK_DIV) < 4) cyc(1'b0, 32'd0, 8'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset seg", 32'(seg), 32'(7'b1111111));
        check("async reset an", 32'(an), 32'hFF);
        @(negedge clk);
        do_reset();
        run_to(FRAME + 2);
        check("pending load discarded", 32'(seg), 32'(7'b0000001));
        check("pending clear after reset", 32'(pending), 32'd0);
        run_to(2 * FRAME + 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
